// File: rtl/uart_nios2_qsys_jtag_ocimem_ctrl.sv
// JTAG debug-RAM access controller for the Nios II on-chip instruction memory.
// Decodes the three JTAG command strobes into single-word reads and writes of
// a synchronous debug RAM, keeps an auto-incrementing word address, returns
// read data through MonDReg and reports busy/overrun status to the debugger.
//
// Handshake: a command strobe is accepted only in the cycle it is presented
// while the controller is idle (monitor_ready=1); there is no back-pressure,
// so a strobe that arrives while busy or loses a same-cycle priority contest
// is dropped and recorded in the sticky monitor_error flag.
module uart_nios2_qsys_jtag_ocimem_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [37:0]       jdo,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [31:0]       ram_rdata,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_ISSUE = 2'd1,
    RD_CAPT  = 2'd2,
    WR       = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       mon_q, mon_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
  logic              err_set;
  logic              err_clr;
  logic              any_strobe;
  logic              unused_jdo;

  // Not every jdo bit carries meaning for this block.
  assign unused_jdo = &{1'b0, jdo};

  assign any_strobe = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;

  // Next-state and datapath decode; the address command wins over write, which wins over streaming read.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    mon_d   = mon_q;
    wdata_d = wdata_q;
    err_set = 1'b0;
    err_clr = take_action_ocimem_a & jdo[35];
    case (state_q)
      IDLE: begin
        if (take_action_ocimem_a) begin
          addr_d  = jdo[ADDR_W+25:26];
          err_set = take_action_ocimem_b | take_no_action_ocimem_a;
          if (jdo[34]) begin
            state_d = RD_ISSUE;
          end
        end else if (take_action_ocimem_b) begin
          wdata_d = jdo[34:3];
          err_set = take_no_action_ocimem_a;
          state_d = WR;
        end else if (take_no_action_ocimem_a) begin
          state_d = RD_ISSUE;
        end
      end
      RD_ISSUE: begin
        err_set = any_strobe;
        state_d = RD_CAPT;
      end
      RD_CAPT: begin
        err_set = any_strobe;
        mon_d   = ram_rdata;
        addr_d  = addr_q + ADDR_W'(1);
        state_d = IDLE;
      end
      WR: begin
        err_set = any_strobe;
        addr_d  = addr_q + ADDR_W'(1);
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // A dropped command must never be hidden by a same-cycle clear.
    if (err_set) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // State and datapath registers; reset aborts any in-flight access at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      mon_q   <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      mon_q   <= mon_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  // RAM strobes decode straight from state so each lasts exactly one cycle and they are exclusive.
  assign ram_re        = (state_q == RD_ISSUE);
  assign ram_we        = (state_q == WR);
  assign ram_addr      = addr_q;
  assign ram_wdata     = wdata_q;
  assign MonDReg       = mon_q;
  assign monitor_ready = (state_q == IDLE);
  assign monitor_error = err_q;

endmodule

// File: tb/tb_uart_nios2_qsys_jtag_ocimem_ctrl.sv
// Bench for the debug-RAM access controller: directed scenarios followed by
// random command traffic, all compared every cycle against a transaction-level
// model that tracks the pending access as a countdown of remaining cycles.
module tb_uart_nios2_qsys_jtag_ocimem_ctrl;

  localparam int AW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          take_action_ocimem_a;
  logic          take_no_action_ocimem_a;
  logic          take_action_ocimem_b;
  logic [37:0]   jdo;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic          ram_we;
  logic          ram_re;
  logic [31:0]   ram_rdata;
  logic [31:0]   MonDReg;
  logic          monitor_ready;
  logic          monitor_error;

  uart_nios2_qsys_jtag_ocimem_ctrl #(.ADDR_W(AW)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .jdo                     (jdo),
    .ram_addr                (ram_addr),
    .ram_wdata               (ram_wdata),
    .ram_we                  (ram_we),
    .ram_re                  (ram_re),
    .ram_rdata               (ram_rdata),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  // ---------------- debug RAM (environment) ----------------
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] = ram_wdata;
    if (ram_re) ram_rdata <= mem[ram_addr];
  end

  // ---------------- scoreboard counters / check ----------------
  int vec_count = 0;
  int err_count = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_count++;
    if (got !== exp) begin
      err_count++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // busy counts the cycles left until the controller is free again:
  // read = 2 (RAM enable cycle, capture cycle), write = 1.
  logic [31:0]   ref_mem [0:255];
  int            m_busy;
  logic          m_rd;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_mon;
  logic [31:0]   m_wdata;
  logic          m_err;
  logic          m_set;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy  = 0;
      m_rd    = 1'b0;
      m_addr  = '0;
      m_mon   = '0;
      m_wdata = '0;
      m_err   = 1'b0;
    end else begin
      m_set = 1'b0;
      if (m_busy == 0) begin
        if (take_action_ocimem_a) begin
          m_addr = jdo[33:26];
          m_set  = take_action_ocimem_b | take_no_action_ocimem_a;
          if (jdo[34]) begin
            m_busy = 2;
            m_rd   = 1'b1;
          end
        end else if (take_action_ocimem_b) begin
          m_wdata = jdo[34:3];
          m_set   = take_no_action_ocimem_a;
          m_busy  = 1;
          m_rd    = 1'b0;
        end else if (take_no_action_ocimem_a) begin
          m_busy = 2;
          m_rd   = 1'b1;
        end
      end else begin
        m_set = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
        if (m_busy == 1) begin
          if (m_rd) m_mon = ref_mem[m_addr];
          else      ref_mem[m_addr] = m_wdata;
          m_addr = m_addr + 8'd1;
        end
        m_busy = m_busy - 1;
      end
      if (m_set) m_err = 1'b1;
      else if (take_action_ocimem_a && jdo[35]) m_err = 1'b0;
    end
  end

  // Every cycle, mid-period, the DUT must agree with the model.
  always @(negedge clk) begin
    check_eq("ram_addr", 32'(ram_addr), 32'(m_addr));
    check_eq("ram_re", 32'(ram_re), 32'(m_rd && m_busy == 2));
    check_eq("ram_we", 32'(ram_we), 32'(!m_rd && m_busy == 1));
    check_eq("MonDReg", MonDReg, m_mon);
    check_eq("ram_wdata", ram_wdata, m_wdata);
    check_eq("monitor_ready", 32'(monitor_ready), 32'(m_busy == 0));
    check_eq("monitor_error", 32'(monitor_error), 32'(m_err));
    check_eq("we_re_excl", 32'(ram_we & ram_re), 32'd0);
  end

  // ---------------- driver tasks ----------------
  function automatic logic [37:0] mk_a(input logic clr, input logic rd, input logic [7:0] addr);
    logic [37:0] j;
    j = '0;
    j[35] = clr;
    j[34] = rd;
    j[33:26] = addr;
    return j;
  endfunction

  function automatic logic [37:0] mk_b(input logic [31:0] data);
    logic [37:0] j;
    j = '0;
    j[34:3] = data;
    return j;
  endfunction

  // Presents one cycle of strobes, returns 1 time unit after the sampling edge.
  task automatic step(input logic a, input logic n, input logic b, input logic [37:0] j);
    @(negedge clk);
    take_action_ocimem_a    = a;
    take_no_action_ocimem_a = n;
    take_action_ocimem_b    = b;
    jdo                     = j;
    @(posedge clk);
    #1;
    take_action_ocimem_a    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b    = 1'b0;
    jdo                     = '0;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 1'b0, 1'b0, '0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    take_action_ocimem_a    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b    = 1'b0;
    jdo                     = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[8'h10] = 32'hDEADBEEF;  ref_mem[8'h10] = 32'hDEADBEEF;
    mem[8'hFF] = 32'hCAFEF00D;  ref_mem[8'hFF] = 32'hCAFEF00D;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready", 32'(monitor_ready), 32'd1);
    check_eq("rst_addr", 32'(ram_addr), 32'd0);
    check_eq("rst_mon", MonDReg, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Read at 0x10
    step(1'b1, 1'b0, 1'b0, mk_a(1'b0, 1'b1, 8'h10));
    check_eq("rd_re_n1", 32'(ram_re), 32'd1);
    check_eq("rd_busy", 32'(monitor_ready), 32'd0);
    idle(2);
    check_eq("rd_mon", MonDReg, 32'hDEADBEEF);
    check_eq("rd_ready", 32'(monitor_ready), 32'd1);
    check_eq("rd_addr", 32'(ram_addr), 32'h11);

    // Write at 0x11
    step(1'b0, 1'b0, 1'b1, mk_b(32'h12345678));
    check_eq("wr_we_n1", 32'(ram_we), 32'd1);
    check_eq("wr_addr", 32'(ram_addr), 32'h11);
    check_eq("wr_data", ram_wdata, 32'h12345678);
    idle(1);
    check_eq("wr_addr_inc", 32'(ram_addr), 32'h12);
    check_eq("wr_ram", mem[8'h11], 32'h12345678);

    // Wrap: address-only command leaves ready high, stream read at 0xFF
    step(1'b1, 1'b0, 1'b0, mk_a(1'b0, 1'b0, 8'hFF));
    check_eq("addr_only_ready", 32'(monitor_ready), 32'd1);
    step(1'b0, 1'b1, 1'b0, '0);
    check_eq("wrap_re_addr", 32'(ram_addr), 32'hFF);
    idle(2);
    check_eq("wrap_mon", MonDReg, 32'hCAFEF00D);
    check_eq("wrap_addr", 32'(ram_addr), 32'h00);

    // Overrun: write during RD_ISSUE is dropped, then cleared
    step(1'b1, 1'b0, 1'b0, mk_a(1'b0, 1'b1, 8'h30));
    step(1'b0, 1'b0, 1'b1, mk_b(32'hA5A5A5A5));
    idle(2);
    check_eq("ovr_err", 32'(monitor_error), 32'd1);
    check_eq("ovr_addr", 32'(ram_addr), 32'h31);
    step(1'b1, 1'b0, 1'b0, mk_a(1'b1, 1'b0, 8'h40));
    check_eq("ovr_clr", 32'(monitor_error), 32'd0);

    // Collision: address command beats write; clear loses to set
    step(1'b1, 1'b0, 1'b1, mk_a(1'b1, 1'b0, 8'h50) | mk_b(32'h0));
    check_eq("col_addr", 32'(ram_addr), 32'h50);
    check_eq("col_we", 32'(ram_we), 32'd0);
    check_eq("col_err", 32'(monitor_error), 32'd1);
    idle(1);

    // Reset during RD_CAPT
    step(1'b1, 1'b0, 1'b0, mk_a(1'b1, 1'b1, 8'h10));
    idle(1);
    check_eq("pre_rst_busy", 32'(monitor_ready), 32'd0);
    reset = 1'b1;
    #1;
    check_eq("rst_capt_mon", MonDReg, 32'd0);
    check_eq("rst_capt_re", 32'(ram_re), 32'd0);
    check_eq("rst_capt_ready", 32'(monitor_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, 1'b0, 1'b0, mk_a(1'b0, 1'b1, 8'h10));
    idle(2);
    check_eq("post_rst_mon", MonDReg, 32'hDEADBEEF);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic ra, rn, rb;
      logic [37:0] rj;
      ra = ($urandom_range(0, 5) == 0);
      rn = ($urandom_range(0, 4) == 0);
      rb = ($urandom_range(0, 4) == 0);
      rj = {6'($urandom), $urandom};
      step(ra, rn, rb, rj);
    end
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule

// File: doc/uart_nios2_qsys_jtag_ocimem_ctrl.md
UART_NIOS2_QSYS_JTAG_OCIMEM_CTRL -- requirements
Module: uart_nios2_qsys_jtag_ocimem_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8: debug RAM word-address width.
REQ-002 The block SHALL have port clk, input, 1: sole clock; all logic is rising-edge.
REQ-003 The block SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 The block SHALL have port take_action_ocimem_a, input, 1: one-cycle strobe for the address/read command.
REQ-005 The block SHALL have port take_no_action_ocimem_a, input, 1: one-cycle strobe for the streaming-read command.
REQ-006 The block SHALL have port take_action_ocimem_b, input, 1: one-cycle strobe for the write command.
REQ-007 The block SHALL have port jdo, input, 38: command payload, valid in the strobe cycle.
REQ-008 The block SHALL have port ram_addr, output, ADDR_W: debug RAM word address.
REQ-009 The block SHALL have port ram_wdata, output, 32: debug RAM write data.
REQ-010 The block SHALL have port ram_we, output, 1: debug RAM write enable.
REQ-011 The block SHALL have port ram_re, output, 1: debug RAM read enable.
REQ-012 The block SHALL have port ram_rdata, input, 32: debug RAM read data, valid 1 cycle after ram_re.
REQ-013 The block SHALL have port MonDReg, output, 32: last word read, returned to the JTAG shift path.
REQ-014 The block SHALL have port monitor_ready, output, 1: high when idle with the last command complete.
REQ-015 The block SHALL have port monitor_error, output, 1: sticky command-overrun flag.

Function
REQ-016 The FSM SHALL have states IDLE, RD_ISSUE, RD_CAPT and WR; only IDLE accepts commands.
REQ-017 On take_action_ocimem_a in IDLE, the block SHALL load the address register from jdo[ADDR_W+25:26]; if jdo[34]=1 it SHALL go to RD_ISSUE, otherwise it SHALL stay in IDLE.
REQ-018 If jdo[35]=1 with take_action_ocimem_a, the block SHALL clear monitor_error; this applies in any state.
REQ-019 On take_no_action_ocimem_a in IDLE, the block SHALL go to RD_ISSUE at the current address.
REQ-020 On take_action_ocimem_b in IDLE, the block SHALL latch jdo[34:3] into ram_wdata and go to WR.
REQ-021 In RD_ISSUE, ram_re SHALL be 1 for exactly one cycle; the next state SHALL be RD_CAPT.
REQ-022 In RD_CAPT, MonDReg SHALL be loaded with ram_rdata, the address SHALL increment by 1, and the next state SHALL be IDLE.
REQ-023 In WR, ram_we SHALL be 1 for exactly one cycle, the address SHALL increment by 1, and the next state SHALL be IDLE.
REQ-024 Address increments SHALL wrap from 2^ADDR_W-1 to 0 with no flag.
REQ-025 Latency: for a strobe at edge N, a read SHALL drive ram_re in cycle N+1, update MonDReg at edge N+2, and raise monitor_ready at edge N+2.
REQ-026 Latency: for a write strobe at edge N, ram_we SHALL be driven in cycle N+1 and monitor_ready SHALL rise at edge N+1.
REQ-027 monitor_ready SHALL drop at the edge that accepts a read or write command; an address-only command SHALL leave it at 1.
REQ-028 Simultaneous strobes SHALL use priority take_action_ocimem_a > take_action_ocimem_b > take_no_action_ocimem_a; losing strobes SHALL be dropped and SHALL set monitor_error.
REQ-029 Any strobe outside IDLE SHALL be ignored, except for its jdo[35] clear, and SHALL set monitor_error; the set SHALL win over a same-cycle clear.
REQ-030 ram_addr SHALL always equal the address register; ram_we and ram_re SHALL never both be 1.

Reset
REQ-031 While reset=1, the block SHALL hold: state IDLE, address 0, MonDReg 0, ram_wdata 0, ram_we 0, ram_re 0, monitor_ready 1, monitor_error 0.
REQ-032 Reset asserted mid-operation SHALL abort any in-flight access immediately, with no partial MonDReg update.

Verification
REQ-033 Read test: take_action_ocimem_a with jdo[33:26]=0x10 and jdo[34]=1, RAM[0x10]=0xDEADBEEF -> ram_re in cycle N+1, MonDReg=0xDEADBEEF and monitor_ready=1 at N+2, address=0x11.
REQ-034 Write test: take_action_ocimem_b with jdo[34:3]=0x12345678 at address 0x11 -> ram_we=1 in cycle N+1 with ram_addr=0x11, then address=0x12.
REQ-035 Wrap test: address 0xFF, take_no_action_ocimem_a -> read at 0xFF, then address=0x00.
REQ-036 Overrun test: take_action_ocimem_b during RD_ISSUE -> write dropped, monitor_error=1; then take_action_ocimem_a with jdo[35]=1 -> monitor_error=0.
REQ-037 Collision test: take_action_ocimem_a and take_action_ocimem_b in the same cycle -> address command executes, no ram_we, monitor_error=1.
REQ-038 Reset test: reset asserted in RD_CAPT -> MonDReg=0, ram_re=0, monitor_ready=1 immediately; normal operation resumes after reset deasserts.
